matrix_stream_loader: RTL

- Host-side streaming front end for the matrix multiplier top.
- Accepts a valid/ready word stream (header + matrix A + matrix B) and writes it into the multiplier's shared memory through its external port.
- Holds the multiplier in reset while loading, then releases it and waits for result_ready.
- Reads the result matrix back and emits it as a valid/ready/last output stream.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matload_dim_check.sv | 66 ++++++
 rtl/matrix_stream_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared state encoding and memory-map constants
// for the matrix stream loader.
package matmul_pkg;

  typedef enum logic [3:0] {
    HDR,
    LOAD,
    START,
    WAIT,
    RADDR,
    RCAP,
    OUT,
    FIN,
    ERR
  } state_e;

  localparam int ADDR_M    = 0;
  localparam int ADDR_N    = 1;
  localparam int ADDR_P    = 2;
  localparam int DATA_BASE = 3;

endpackage

// File: rtl/matload_dim_check.sv
// Combinational header validator: range/size check,
// region base addresses and element counts.
module matload_dim_check
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MAX_LEN     = 100,
  parameter int MAX_LEN_LOG = 7
) (
  input  logic [DATA_WIDTH-1:0]    m_i,
  input  logic [DATA_WIDTH-1:0]    n_i,
  input  logic [DATA_WIDTH-1:0]    p_i,
  output logic                     ok_o,
  output logic [ADDR_WIDTH-1:0]    a_base_o,
  output logic [ADDR_WIDTH-1:0]    b_base_o,
  output logic [ADDR_WIDTH-1:0]    r_base_o,
  output logic [2*MAX_LEN_LOG:0]   ab_cnt_o,
  output logic [2*MAX_LEN_LOG-1:0] res_cnt_o
);

  localparam int PW = 2 * MAX_LEN_LOG;
  localparam int SW = PW + 2;
  localparam longint unsigned CAP =
    64'd1 << ADDR_WIDTH;

  logic [MAX_LEN_LOG-1:0] m, n, p;
  logic [PW-1:0]          mn, np, mp;
  logic [SW-1:0]          total;
  logic                   in_range;

  function automatic logic dim_ok(
    input logic [DATA_WIDTH-1:0] d
  );
    return (d != '0) &&
           (d <= DATA_WIDTH'(MAX_LEN));
  endfunction

  assign m = m_i[MAX_LEN_LOG-1:0];
  assign n = n_i[MAX_LEN_LOG-1:0];
  assign p = p_i[MAX_LEN_LOG-1:0];

  assign mn = PW'(m) * PW'(n);
  assign np = PW'(n) * PW'(p);
  assign mp = PW'(m) * PW'(p);

  assign total = SW'(DATA_BASE) + SW'(mn)
               + SW'(np) + SW'(mp);

  assign in_range = dim_ok(m_i) &&
                    dim_ok(n_i) &&
                    dim_ok(p_i);

  // products are only meaningful once the dims are in range
  assign ok_o = in_range && (64'(total) <= CAP);

  assign a_base_o = ADDR_WIDTH'(DATA_BASE);
  assign b_base_o =
    ADDR_WIDTH'(SW'(DATA_BASE) + SW'(mn));
  assign r_base_o =
    ADDR_WIDTH'(SW'(DATA_BASE) + SW'(mn) + SW'(np));

  assign ab_cnt_o  = (PW+1)'(mn) + (PW+1)'(np);
  assign res_cnt_o = mp;

endmodule

// File: rtl/matrix_stream_loader.sv
// Stream loader/unloader for the matrix multiplier.
// Define MATLOAD_CHECKSUM_EN to append a result checksum word.
module matrix_stream_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MAX_LEN     = 100,
  parameter int MAX_LEN_LOG = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  result_ready,
  output logic                  mult_reset,
  output logic                  busy,
  output logic                  error
);

  localparam int PW = 2 * MAX_LEN_LOG;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wcnt_q, r_base_q;
  logic [DATA_WIDTH-1:0] m_q, n_q, out_data_q;
  logic [PW-1:0]         idx_q, last_idx_q;

  logic                  ok;
  logic [ADDR_WIDTH-1:0] a_base, b_base, r_base;
  logic [PW:0]           ab_cnt;
  logic [PW-1:0]         res_cnt;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  xfer, rd_phase, last_res;
  logic                  unused_dims;

`ifdef MATLOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  csum_phase_q;
`endif

  matload_dim_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_LEN    (MAX_LEN),
    .MAX_LEN_LOG(MAX_LEN_LOG)
  ) u_dim (
    .m_i      (m_q),
    .n_i      (n_q),
    .p_i      (in_data),
    .ok_o     (ok),
    .a_base_o (a_base),
    .b_base_o (b_base),
    .r_base_o (r_base),
    .ab_cnt_o (ab_cnt),
    .res_cnt_o(res_cnt)
  );

  assign unused_dims = ^{a_base, b_base, ab_cnt};

  assign in_ready = (state_q == HDR) ||
                    (state_q == LOAD);
  // a reset cycle must never leak a write
  assign xfer = in_valid && in_ready && !reset;

  assign mem_write_enable = xfer;
  assign mem_data_out     = xfer ? in_data : '0;

  assign rd_phase = (state_q == RADDR) ||
                    (state_q == RCAP);
  assign raddr    = r_base_q + ADDR_WIDTH'(idx_q);
  assign last_res = (idx_q == last_idx_q);

  always_comb begin
    mem_address = '0;
    unique case (1'b1)
      in_ready: mem_address = wcnt_q;
      rd_phase: mem_address = raddr;
      default:  mem_address = '0;
    endcase
  end

  assign out_data   = out_data_q;
  assign out_valid  = (state_q == OUT);
  assign busy       = (state_q != HDR);
  assign error      = (state_q == ERR);
  assign mult_reset = !(state_q inside
    {START, WAIT, RADDR, RCAP, OUT});

`ifdef MATLOAD_CHECKSUM_EN
  assign out_last = out_valid && csum_phase_q;
`else
  assign out_last = out_valid && last_res;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HDR;
      wcnt_q     <= '0;
      m_q        <= '0;
      n_q        <= '0;
      r_base_q   <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      out_data_q <= '0;
`ifdef MATLOAD_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        HDR: begin
`ifdef MATLOAD_CHECKSUM_EN
          csum_q       <= '0;
          csum_phase_q <= 1'b0;
`endif
          if (xfer) begin
            wcnt_q <= wcnt_q + ADDR_WIDTH'(1);
            if (wcnt_q == ADDR_WIDTH'(ADDR_M))
              m_q <= in_data;
            if (wcnt_q == ADDR_WIDTH'(ADDR_N))
              n_q <= in_data;
            if (wcnt_q == ADDR_WIDTH'(ADDR_P)) begin
              r_base_q   <= r_base;
              last_idx_q <= res_cnt - PW'(1);
              state_q    <= ok ? LOAD : ERR;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            wcnt_q <= wcnt_q + ADDR_WIDTH'(1);
            if (wcnt_q == r_base_q - ADDR_WIDTH'(1))
              state_q <= START;
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (result_ready) begin
            idx_q   <= '0;
            state_q <= RADDR;
          end
        end
        RADDR: state_q <= RCAP;
        RCAP: begin
          out_data_q <= mem_data_in;
          state_q    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
`ifdef MATLOAD_CHECKSUM_EN
            if (csum_phase_q) begin
              state_q <= FIN;
            end else if (last_res) begin
              csum_phase_q <= 1'b1;
              out_data_q   <= csum_q + out_data_q;
            end else begin
              csum_q  <= csum_q + out_data_q;
              idx_q   <= idx_q + PW'(1);
              state_q <= RADDR;
            end
`else
            if (last_res) begin
              state_q <= FIN;
            end else begin
              idx_q   <= idx_q + PW'(1);
              state_q <= RADDR;
            end
`endif
          end
        end
        FIN: begin
          wcnt_q  <= '0;
          state_q <= HDR;
        end
        ERR:     state_q <= ERR;
        default: state_q <= HDR;
      endcase
    end
  end

endmodule
